// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and round-robin helper for stream arbiters
package axis_arb_pkg;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  localparam int RR_MAXN = 16;

  // Scans last+1, last+2, ... modulo n; returns last itself when nothing requests.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] last,
                                         input int n);
    logic [3:0] pick;
    int k;
    pick = last;
    for (int i = RR_MAXN; i >= 1; i--) begin
      if (i <= n) begin
        k = (int'(last) + i) % n;
        if (req[k[3:0]]) pick = k[3:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// rtl/rr_priority_sel.sv - combinational round-robin picker starting after the last winner
module rr_priority_sel
  import axis_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] idx,
  output logic           any
);

  assign idx = IDW'(rr_pick(16'(req), 4'(last), N));
  assign any = |req;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - N:1 stream arbiter, round-robin grants locked for a whole packet
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int DW  = 16,
  parameter int IDW = 2,
  parameter int CW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] s_tdata,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N-1:0]    s_tlast,
  output logic [N-1:0]    s_tready,
  output logic [DW-1:0]   m_tdata,
  output logic            m_tvalid,
  output logic            m_tlast,
  output logic [IDW-1:0]  m_tid,
  input  logic            m_tready,
  output logic            busy,
  output logic [CW-1:0]   pkt_cnt
);

  arb_state_t     state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           lock;

  rr_priority_sel #(.N(N), .IDW(IDW)) u_sel (
    .req  (s_tvalid),
    .last (last_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign lock  = (state == LOCK);
  assign busy  = lock;
  assign m_tid = grant;

  // Zero-latency datapath: the granted source is wired straight through while locked.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (lock) begin
      m_tdata         = s_tdata[grant*DW +: DW];
      m_tvalid        = s_tvalid[grant];
      m_tlast         = s_tlast[grant];
      s_tready[grant] = m_tready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDW'(N - 1);
      pkt_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_idx;
            state <= LOCK;
          end
        end
        LOCK: begin
          // Lock releases only on the accepted tlast beat; stalls and gaps keep it.
          if (m_tvalid && m_tready && m_tlast) begin
            last_grant <= grant;
            pkt_cnt    <= pkt_cnt + CW'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - randomized bench for axis_pkt_arbiter against a behavioural model
module tb_axis_pkt_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IDW = 2;
  localparam int CW  = 4;
  localparam int NCYC = 6000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic [IDW-1:0]  m_tid;
  logic            m_tready;
  logic            busy;
  logic [CW-1:0]   pkt_cnt;

  axis_pkt_arbiter #(.N(N), .DW(DW), .IDW(IDW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source side: each port owns a packet in progress and presents one beat at a time.
  bit            cur_valid [N];
  bit            cur_last  [N];
  logic [DW-1:0] cur_data  [N];
  int            left      [N];
  bit            in_pkt    [N];
  bit            hs        [N];

  // Reference: owner of the current packet (-1 = arbitrating), previous winner, packet count.
  int owner;
  int last_g;
  int cnt;

  initial begin
    rst      = 1'b1;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    owner    = -1;
    last_g   = N - 1;
    cnt      = 0;
    for (int i = 0; i < N; i++) begin
      cur_valid[i] = 1'b0;
      cur_last[i]  = 1'b0;
      cur_data[i]  = '0;
      left[i]      = 0;
      in_pkt[i]    = 1'b0;
      hs[i]        = 1'b0;
    end
    @(negedge clk);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int p_valid;
      int p_ready;
      int max_len;
      logic [N-1:0] act;
      logic [N-1:0] exp_ready;
      bit exp_valid;

      if (cyc < 1500) begin
        p_valid = 100; p_ready = 100; max_len = 3; act = '1;
      end else if (cyc < 3000) begin
        p_valid = 70;  p_ready = 70;  max_len = 6; act = '1;
      end else if (cyc < 3600) begin
        p_valid = 100; p_ready = 100; max_len = 1; act = 4'b0001;
      end else begin
        p_valid = 60;  p_ready = 60;  max_len = 5; act = 4'(($urandom_range(15)));
      end

      rst      = (cyc < 3) || (cyc >= 3600 && $urandom_range(149) == 0);
      m_tready = ($urandom_range(99) < p_ready);

      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          cur_valid[i] = 1'b0;
          if (cur_last[i]) in_pkt[i] = 1'b0;
        end
        if (!cur_valid[i]) begin
          if (!in_pkt[i] && act[i]) begin
            in_pkt[i] = 1'b1;
            left[i]   = $urandom_range(max_len, 1);
          end
          if (in_pkt[i] && $urandom_range(99) < p_valid) begin
            cur_valid[i] = 1'b1;
            cur_data[i]  = DW'($urandom);
            left[i]--;
            cur_last[i]  = (left[i] == 0);
          end
        end
        s_tvalid[i]         = cur_valid[i];
        s_tdata[i*DW +: DW] = cur_valid[i] ? cur_data[i] : DW'($urandom);
        s_tlast[i]          = cur_valid[i] ? cur_last[i] : 1'($urandom_range(1));
      end

      #1;
      exp_valid = (owner >= 0) && cur_valid[owner];
      exp_ready = (owner >= 0 && m_tready) ? (N'(1) << owner) : '0;
      if (cyc > 0) begin
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("m_tvalid", 32'(m_tvalid), 32'(exp_valid));
        chk("s_tready", 32'(s_tready), 32'(exp_ready));
        chk("pkt_cnt", 32'(pkt_cnt), 32'(cnt));
        if (exp_valid) begin
          chk("m_tid", 32'(m_tid), 32'(owner));
          chk("m_tdata", 32'(m_tdata), 32'(cur_data[owner]));
          chk("m_tlast", 32'(m_tlast), 32'(cur_last[owner]));
        end
      end

      for (int i = 0; i < N; i++) hs[i] = cur_valid[i] && exp_ready[i];

      if (rst) begin
        owner  = -1;
        last_g = N - 1;
        cnt    = 0;
      end else if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (last_g + k) % N;
          if (cur_valid[p]) begin
            owner = p;
            break;
          end
        end
      end else if (cur_valid[owner] && m_tready && cur_last[owner]) begin
        last_g = owner;
        cnt    = (cnt + 1) % (1 << CW);
        owner  = -1;
      end

      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
